// File: rtl/syzygy_adc_enc_pkg.sv
// Shared constants for the SYZYGY ADC encode-clock generator: FSM state encoding
// and default parameter values.
package syzygy_adc_enc_pkg;

   localparam int unsigned NUM_CH_DEF       = 2;
   localparam int unsigned DIV_W_DEF        = 8;
   localparam int unsigned WARMUP_EDGES_DEF = 16;

   localparam int unsigned EDGE_CNT_W = 8;
   localparam int unsigned ST_W       = 2;

   localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [ST_W-1:0] ST_WARMUP = 2'd1;
   localparam logic [ST_W-1:0] ST_RUN    = 2'd2;
   localparam logic [ST_W-1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/syzygy_adc_enc_div.sv
// Shared half-period counter and encode phase toggle. Exposes the next phase so
// the parent can register all channel outputs in step with it.
module syzygy_adc_enc_div
   import syzygy_adc_enc_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             run,
   input  logic             allow_rise,
   input  logic [DIV_W-1:0] div,
   output logic             phase_next_c,
   output logic             rise_c
);

   logic [DIV_W-1:0] half_q;
   logic [DIV_W-1:0] half_next;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_next;
   logic             phase;
   logic             term_c;

   assign term_c = (cnt == DIV_W'(half_q - DIV_W'(1)));

   // Load starts a high phase; a blocked rise leaves the phase low so the parent can finish.
   always_comb begin
      half_next    = half_q;
      cnt_next     = cnt;
      phase_next_c = phase;
      if (load) begin
         half_next    = (div == '0) ? DIV_W'(1) : div;
         cnt_next     = '0;
         phase_next_c = 1'b1;
      end else if (run) begin
         if (term_c) begin
            cnt_next     = '0;
            phase_next_c = phase ? 1'b0 : allow_rise;
         end else begin
            cnt_next = DIV_W'(cnt + DIV_W'(1));
         end
      end else begin
         cnt_next     = '0;
         phase_next_c = 1'b0;
      end
   end

   assign rise_c = ~phase & phase_next_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         half_q <= '0;
         cnt    <= '0;
         phase  <= 1'b0;
      end else begin
         half_q <= half_next;
         cnt    <= cnt_next;
         phase  <= phase_next_c;
      end
   end

endmodule

// File: rtl/syzygy_adc_enc_gen.sv
// ADC encode clock generator with warmup, run and drain phases.
// Optional ADC_ENC_SAMPLE_CNT_EN adds a saturating count of run-phase rising edges.
module syzygy_adc_enc_gen
   import syzygy_adc_enc_pkg::*;
#(
   parameter int unsigned NUM_CH       = NUM_CH_DEF,
   parameter int unsigned DIV_W        = DIV_W_DEF,
   parameter int unsigned WARMUP_EDGES = WARMUP_EDGES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [DIV_W-1:0]  div,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] adc_encode,
   output logic [NUM_CH-1:0] adc_encode_t,
   output logic              busy,
   output logic              ready
`ifdef ADC_ENC_SAMPLE_CNT_EN
   ,
   output logic [31:0]       sample_count
`endif
);

   localparam int unsigned EDGE_CMP_W = EDGE_CNT_W + 1;

   logic [ST_W-1:0]       state;
   logic [ST_W-1:0]       state_next;
   logic [EDGE_CNT_W-1:0] edge_cnt;
   logic [EDGE_CNT_W-1:0] edge_cnt_next;
   logic [NUM_CH-1:0]     en_q;
   logic [NUM_CH-1:0]     en_next;
   logic [NUM_CH-1:0]     encode_next;
   logic [NUM_CH-1:0]     encode_t_next;
   logic                  busy_next;
   logic                  ready_next;
   logic                  load_c;
   logic                  run_c;
   logic                  allow_rise_c;
   logic                  phase_next_c;
   logic                  rise_c;

   // Stop dominates start; start is only honoured from IDLE.
   assign load_c       = (state == ST_IDLE) && start && !stop;
   assign run_c        = (state != ST_IDLE);
   assign allow_rise_c = ((state == ST_WARMUP) || (state == ST_RUN)) && !stop;

   syzygy_adc_enc_div #(
      .DIV_W(DIV_W)
   ) u_div (
      .clk         (clk),
      .reset       (reset),
      .load        (load_c),
      .run         (run_c),
      .allow_rise  (allow_rise_c),
      .div         (div),
      .phase_next_c(phase_next_c),
      .rise_c      (rise_c)
   );

   always_comb begin
      state_next    = state;
      edge_cnt_next = edge_cnt;
      en_next       = en_q;
      case (state)
         ST_IDLE: begin
            if (load_c) begin
               en_next       = ch_en;
               edge_cnt_next = EDGE_CNT_W'(1);
               state_next    = (WARMUP_EDGES == 1) ? ST_RUN : ST_WARMUP;
            end
         end
         ST_WARMUP: begin
            if (stop) begin
               state_next = ST_DRAIN;
            end else if (rise_c) begin
               if (edge_cnt != '1) begin
                  edge_cnt_next = EDGE_CNT_W'(edge_cnt + EDGE_CNT_W'(1));
               end
               if ((EDGE_CMP_W'(edge_cnt) + EDGE_CMP_W'(1)) == EDGE_CMP_W'(WARMUP_EDGES)) begin
                  state_next = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!phase_next_c) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Outputs follow the next state so they land in the same cycle as the transition.
      busy_next     = (state_next != ST_IDLE);
      ready_next    = (state_next == ST_RUN);
      encode_next   = busy_next ? ({NUM_CH{phase_next_c}} & en_next) : '0;
      encode_t_next = busy_next ? ~en_next : '1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         edge_cnt     <= '0;
         en_q         <= '0;
         adc_encode   <= '0;
         adc_encode_t <= '1;
         busy         <= 1'b0;
         ready        <= 1'b0;
      end else begin
         state        <= state_next;
         edge_cnt     <= edge_cnt_next;
         en_q         <= en_next;
         adc_encode   <= encode_next;
         adc_encode_t <= encode_t_next;
         busy         <= busy_next;
         ready        <= ready_next;
      end
   end

`ifdef ADC_ENC_SAMPLE_CNT_EN
   // Counts rising edges emitted while in RUN; holds after stop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_count <= '0;
      end else if (load_c) begin
         sample_count <= '0;
      end else if ((state_next == ST_RUN) && rise_c && (sample_count != '1)) begin
         sample_count <= sample_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_syzygy_adc_enc_gen.sv
// Scoreboard bench for syzygy_adc_enc_gen: expected per-cycle outputs come from a
// closed-form waveform model and are queued as stimulus is driven.
module tb_syzygy_adc_enc_gen;

   localparam int unsigned W = 4;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic [7:0] div;
   logic [1:0] ch_en;
   logic [1:0] adc_encode;
   logic [1:0] adc_encode_t;
   logic       busy;
   logic       ready;
`ifdef ADC_ENC_SAMPLE_CNT_EN
   logic [31:0] sample_count;
`endif

   int n_tot = 0;
   int n_bad = 0;
   logic [5:0] exp_q[$];

   syzygy_adc_enc_gen #(
      .NUM_CH      (2),
      .DIV_W       (8),
      .WARMUP_EDGES(W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .div         (div),
      .ch_en       (ch_en),
      .adc_encode  (adc_encode),
      .adc_encode_t(adc_encode_t),
      .busy        (busy),
      .ready       (ready)
`ifdef ADC_ENC_SAMPLE_CNT_EN
      ,
      .sample_count(sample_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected {encode, encode_t, busy, ready} for cycle k after start (start seen in cycle 0).
   function automatic logic [5:0] ref_obs(input int k, input int d_raw, input logic [1:0] en, input int ks);
      int d;
      int p;
      int q;
      int pend;
      logic h;
      logic [5:0] idle_v;
      idle_v = {2'b00, 2'b11, 1'b0, 1'b0};
      d = (d_raw == 0) ? 1 : d_raw;
      if (k <= 0) return idle_v;
      p = k - 1;
      h = ((p / d) % 2) == 0;
      if (ks < 0 || k <= ks) begin
         return {(h ? en : 2'b00), ~en, 1'b1, (p >= 2 * d * (W - 1))};
      end
      q = ks;
      if (((q / d) % 2) == 0 && (q % d) != 0) begin
         pend = (q / d + 1) * d;
         if (p < pend) return {en, ~en, 1'b1, 1'b0};
         return idle_v;
      end
      if (p == q) return {2'b00, ~en, 1'b1, 1'b0};
      return idle_v;
   endfunction

   task automatic run_scn(input string nm, input int d, input logic [1:0] en, input int ks,
                          input int ncyc, input bit both);
      logic [5:0] exp_v;
      logic [5:0] got;
      exp_q.push_back(ref_obs(0, d, en, ks));
      for (int k = 0; k <= ncyc; k++) begin
         @(posedge clk);
         #1;
         start = (k == 0) || (k == 2) || (both && k == ks);
         stop  = (k == ks);
         div   = (k == 0) ? 8'(d) : 8'($urandom);
         ch_en = (k == 0) ? en : 2'($urandom);
         exp_q.push_back(ref_obs(k + 1, d, en, ks));
         @(negedge clk);
         exp_v = exp_q.pop_front();
         got   = {adc_encode, adc_encode_t, busy, ready};
         check_val($sformatf("%s k=%0d", nm, k), 32'(got), 32'(exp_v));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got   = {adc_encode, adc_encode_t, busy, ready};
      check_val($sformatf("%s tail", nm), 32'(got), 32'(exp_v));
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      div   = 8'd0;
      ch_en = 2'b00;
      #1;
      check_val("rst_enc", 32'(adc_encode), 32'h0);
      check_val("rst_t", 32'(adc_encode_t), 32'h3);
      check_val("rst_busy", 32'(busy), 32'h0);
      check_val("rst_ready", 32'(ready), 32'h0);
`ifdef ADC_ENC_SAMPLE_CNT_EN
      check_val("rst_scnt", sample_count, 32'h0);
`endif
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(posedge clk);

      run_scn("div3", 3, 2'b11, 8, 14, 1'b0);
      run_scn("warm4", 1, 2'b11, 12, 16, 1'b0);
      run_scn("drain4", 4, 2'b11, 10, 16, 1'b0);
      run_scn("ch0d0", 0, 2'b01, 9, 14, 1'b0);
      run_scn("run3", 3, 2'b10, 25, 32, 1'b0);
      run_scn("ststop", 2, 2'b10, 20, 26, 1'b1);
      run_scn("lowstop", 5, 2'b10, 7, 12, 1'b0);

      // Start together with stop in IDLE must not leave IDLE.
      @(posedge clk);
      #1;
      start = 1'b1;
      stop  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      @(negedge clk);
      check_val("idle_ss_busy", 32'(busy), 32'h0);
      check_val("idle_ss_t", 32'(adc_encode_t), 32'h3);

      // Asynchronous reset in the middle of RUN.
      run_scn("prerst", 1, 2'b11, -1, 9, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_val("arst_enc", 32'(adc_encode), 32'h0);
      check_val("arst_t", 32'(adc_encode_t), 32'h3);
      check_val("arst_busy", 32'(busy), 32'h0);
      check_val("arst_ready", 32'(ready), 32'h0);
`ifdef ADC_ENC_SAMPLE_CNT_EN
      check_val("arst_scnt", sample_count, 32'h0);
`endif
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_val("post_rst_busy", 32'(busy), 32'h0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/syzygy_adc_enc_gen.md
SYZYGY_ADC_ENC_GEN -- requirements
Module: syzygy_adc_enc_gen

Interface
REQ-001 Parameter NUM_CH, default 2: number of ADC encode channels, range 1..8.
REQ-002 Parameter DIV_W, default 8: width of the half-period divider input.
REQ-003 Parameter WARMUP_EDGES, default 16: encode rising edges generated before ready asserts, range 1..255.
REQ-004 Port clk  input  1: single clock; all logic is clocked on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port start  input  1: single-cycle request to begin encoding.
REQ-007 Port stop  input  1: single-cycle request to end encoding.
REQ-008 Port div  input  DIV_W: encode half-period in clk cycles, sampled at start.
REQ-009 Port ch_en  input  NUM_CH: per-channel enable, sampled at start.
REQ-010 Port adc_encode  output  NUM_CH: registered encode clock per channel.
REQ-011 Port adc_encode_t  output  NUM_CH: per-channel tri-state control, 1 = high-Z, for the pad OBUFT T pin.
REQ-012 Port busy  output  1: high in every state except IDLE.
REQ-013 Port ready  output  1: high only in RUN.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, WARMUP, RUN, DRAIN.
REQ-015 IDLE->WARMUP on start; the cycle after start, busy=1, adc_encode_t=~ch_en_latched, and adc_encode of enabled channels goes high.
REQ-016 The latched div value SHALL be used as the half-period; div=0 SHALL be treated as 1; changes to div or ch_en while busy SHALL be ignored.
REQ-017 Enabled channels SHALL be high for div cycles, then low for div cycles, repeating; disabled channels SHALL hold adc_encode=0 and adc_encode_t=1.
REQ-018 WARMUP->RUN when the WARMUP_EDGES-th rising edge has been emitted; ready SHALL assert in the same cycle as that edge.
REQ-019 WARMUP or RUN->DRAIN on stop; ready SHALL deassert the cycle after stop.
REQ-020 In DRAIN, a current high phase SHALL complete its full div cycles; no new rising edge SHALL be emitted.
REQ-021 DRAIN->IDLE on the first cycle where adc_encode is low; on entry to IDLE all adc_encode_t=1 and busy=0.
REQ-022 start and stop asserted together SHALL be treated as stop; start while busy SHALL be ignored; stop in IDLE SHALL be ignored.
REQ-023 Half-period counter width SHALL be DIV_W; the warmup edge counter SHALL be 8 bits and SHALL NOT wrap.

Reset
REQ-024 On reset, state=IDLE, adc_encode=0, adc_encode_t=all ones, busy=0, ready=0, and all counters and latches cleared, immediately and independently of clk.
REQ-025 Reset asserted mid-operation SHALL abort without draining; the pads SHALL go high-Z asynchronously.

Configuration
REQ-026 Macro ADC_ENC_SAMPLE_CNT_EN defined: add output sample_count[31:0], cleared on start, incremented on each rising edge emitted in RUN, saturating at 32'hFFFFFFFF, held after stop, cleared on reset.
REQ-027 Macro ADC_ENC_SAMPLE_CNT_EN undefined: no sample_count port and no counter logic.

Structure
REQ-028 Package syzygy_adc_enc_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-029 The half-period counter and toggle SHALL live in a sub-module syzygy_adc_enc_div, instantiated once and shared by all channels.

Verification
REQ-030 NUM_CH=2, ch_en=2'b11, div=3, start at cycle 10 -> encode high on cycles 11-13, low on 14-16; adc_encode_t=0 from cycle 11.
REQ-031 WARMUP_EDGES=4, div=1 -> ready rises on cycle 17 with the 4th rising edge, after start at cycle 10.
REQ-032 div=4, stop one cycle after a rising edge -> high phase completes its 4 cycles, then busy=0 and adc_encode_t=2'b11 on the first low cycle.
REQ-033 ch_en=2'b01, div=0 -> ch0 toggles every cycle; ch1 holds 0 with adc_encode_t[1]=1.
REQ-034 start and stop asserted together in RUN -> DRAIN entered; start in the same cycle as stop while IDLE -> stays IDLE.
REQ-035 Reset asserted mid-RUN between clock edges -> outputs reach reset values before the next clk edge; with ADC_ENC_SAMPLE_CNT_EN, sample_count=0.
